// File: rtl/coherence_bus_arbiter_if.sv
// Cache- and RAM-side signal bundle for coherence_bus_arbiter.
// master = arbiter view, slave = cache/memory view.
interface coherence_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned NCORES = 2
);
    logic [NCORES-1:0]             iREN;
    logic [NCORES-1:0][ADDR_W-1:0] iaddr;
    logic [NCORES-1:0]             iwait;
    logic [NCORES-1:0][ADDR_W-1:0] iload;

    logic [NCORES-1:0]             dREN;
    logic [NCORES-1:0]             dWEN;
    logic [NCORES-1:0][ADDR_W-1:0] daddr;
    logic [NCORES-1:0][ADDR_W-1:0] dstore;
    logic [NCORES-1:0]             ccwrite;
    logic [NCORES-1:0]             dwait;
    logic [NCORES-1:0][ADDR_W-1:0] dload;

    logic [NCORES-1:0]             ccwait;
    logic [NCORES-1:0]             ccinv;
    logic [NCORES-1:0][ADDR_W-1:0] ccsnoopaddr;

    logic                          ramREN;
    logic                          ramWEN;
    logic [ADDR_W-1:0]             ramaddr;
    logic [ADDR_W-1:0]             ramstore;
    logic [ADDR_W-1:0]             ramload;
    logic                          ram_ready;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, ramload, ram_ready,
        output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, ramload, ram_ready,
        input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// Two-core shared-RAM arbiter with MSI snooping between the dcaches.
// Define ARB_ROUND_ROBIN_EN for round-robin between cores; default is fixed core-0 priority.
module coherence_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned NCORES = 2
) (
    input logic                     CLK,
    input logic                     RST,
    coherence_bus_arbiter_if.master bus
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_INV,
        S_SNOOP,
        S_C2C,
        S_MEMRD,
        S_IFETCH
    } state_e;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_core_q, last_core_d;
    logic              other;
    logic              winner;
    logic [NCORES-1:0] dreq;
    logic [NCORES-1:0] cand;
    logic [ADDR_W-1:0] snoop_addr;

    // Dcache traffic (read, write, upgrade) outranks every icache request.
    always_comb begin
        dreq   = bus.dREN | bus.dWEN | bus.ccwrite;
        cand   = (dreq != '0) ? dreq : bus.iREN;
        winner = (&cand) ? (RR_EN & ~last_core_q) : cand[1];
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_core_d      = last_core_q;
        other            = ~grant_q;
        snoop_addr       = bus.daddr[grant_q];

        bus.iwait        = '1;
        bus.dwait        = '1;
        bus.iload        = '0;
        bus.dload        = '0;
        bus.ccwait       = '0;
        bus.ccinv        = '0;
        bus.ccsnoopaddr  = '0;
        bus.ramREN       = 1'b0;
        bus.ramWEN       = 1'b0;
        bus.ramaddr      = '0;
        bus.ramstore     = '0;

        case (state_q)
            S_IDLE: begin
                if (cand != '0) begin
                    grant_d = winner;
                    if (bus.dWEN[winner])      state_d = S_WB;
                    else if (bus.dREN[winner]) state_d = S_SNOOP;
                    else if (dreq[winner])     state_d = S_INV;
                    else                       state_d = S_IFETCH;
                end
            end
            S_WB: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = bus.daddr[grant_q];
                bus.ramstore = bus.dstore[grant_q];
                if (bus.ram_ready) begin
                    bus.dwait[grant_q] = 1'b0;
                    last_core_d        = grant_q;
                    state_d            = S_IDLE;
                end
            end
            S_INV: begin
                bus.ccwait[other]      = 1'b1;
                bus.ccinv[other]       = 1'b1;
                bus.ccsnoopaddr[other] = snoop_addr;
                last_core_d            = grant_q;
                state_d                = S_IDLE;
            end
            S_SNOOP: begin
                bus.ccwait[other]      = 1'b1;
                bus.ccinv[other]       = bus.ccwrite[grant_q];
                bus.ccsnoopaddr[other] = snoop_addr;
                state_d = bus.ccwrite[other] ? S_C2C : S_MEMRD;
            end
            S_C2C: begin
                // Peer supplies the line; memory is written back in the same access.
                bus.ccwait[other]      = 1'b1;
                bus.ccsnoopaddr[other] = snoop_addr;
                bus.dload[grant_q]     = bus.dstore[other];
                bus.ramWEN             = 1'b1;
                bus.ramaddr            = bus.daddr[grant_q];
                bus.ramstore           = bus.dstore[other];
                if (bus.ram_ready) begin
                    bus.dwait[grant_q] = 1'b0;
                    last_core_d        = grant_q;
                    state_d            = S_IDLE;
                end
            end
            S_MEMRD: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.daddr[grant_q];
                if (bus.ram_ready) begin
                    bus.dload[grant_q] = bus.ramload;
                    bus.dwait[grant_q] = 1'b0;
                    last_core_d        = grant_q;
                    state_d            = S_IDLE;
                end
            end
            S_IFETCH: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr[grant_q];
                if (bus.ram_ready) begin
                    bus.iload[grant_q] = bus.ramload;
                    bus.iwait[grant_q] = 1'b0;
                    last_core_d        = grant_q;
                    state_d            = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            grant_q     <= 1'b0;
            last_core_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_core_q <= last_core_d;
        end
    end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Randomized self-checking bench for coherence_bus_arbiter with a transaction-level reference model.
`timescale 1ns/1ps
module tb_coherence_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef enum int {K_NONE, K_IRD, K_DRD, K_DRX, K_DWR, K_UPG} kind_e;
    typedef struct {
        int          core;
        kind_e       kind;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    coherence_bus_arbiter_if #(.ADDR_W(32), .NCORES(2)) bus ();
    coherence_bus_arbiter #(.ADDR_W(32), .NCORES(2)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int          n_vec = 0;
    int          n_err = 0;
    int          m_last = 1;
    logic [31:0] ram_mem [0:1023];
    logic [31:0] ref_mem [0:31];
    bit          snp_mod [2];
    logic [31:0] snp_dat [2];
    bit          dbusy [2];
    kind_e       rk [2];
    bit          wr_pend = 1'b0;
    logic [9:0]  wr_a;
    logic [31:0] wr_d;
    txn_t        expq [$];
    int          grants [$];

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_d(kind_e k);
        return (k == K_DRD) || (k == K_DRX) || (k == K_DWR) || (k == K_UPG);
    endfunction

    // Spec rule: dcache class first; within a class fixed core0 or the core that did not go last.
    function automatic int pick(bit [1:0] p);
        bit [1:0] dc, ic, cand;
        for (int c = 0; c < 2; c++) begin
            dc[c] = p[c] && is_d(rk[c]);
            ic[c] = p[c] && (rk[c] == K_IRD);
        end
        cand = (dc != 2'b00) ? dc : ic;
        if (cand == 2'b11) return (RR && m_last == 0) ? 1 : 0;
        return cand[1] ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge CLK);
        if (wr_pend) ram_mem[wr_a] = wr_d;
        wr_pend = 1'b0;
        #1;
    endtask

    task automatic settle();
        #1;
        bus.ramload = ram_mem[bus.ramaddr[9:0]];
        for (int c = 0; c < 2; c++) begin
            if (!dbusy[c]) begin
                bus.dstore[c]  = snp_dat[c];
                bus.ccwrite[c] = bus.ccwait[c] & snp_mod[c];
            end
        end
        @(negedge CLK);
        wr_pend = bus.ramWEN && bus.ram_ready;
        wr_a    = bus.ramaddr[9:0];
        wr_d    = bus.ramstore;
    endtask

    task automatic drive_req(int c, kind_e k, logic [31:0] a, logic [31:0] d);
        rk[c]          = k;
        bus.iREN[c]    = (k == K_IRD);
        bus.iaddr[c]   = a;
        bus.dREN[c]    = (k == K_DRD) || (k == K_DRX);
        bus.dWEN[c]    = (k == K_DWR);
        bus.ccwrite[c] = (k == K_DRX) || (k == K_UPG);
        bus.daddr[c]   = a;
        dbusy[c]       = is_d(k);
        if (dbusy[c]) bus.dstore[c] = d;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive_req(c, K_NONE, 32'h0, 32'h0);
            snp_mod[c] = 1'b0;
        end
        bus.ram_ready = 1'b0;
        tick();
        settle();
        tick();
        RST    = 1'b0;
        m_last = 1;
        settle();
    endtask

    task automatic run_round();
        logic [4:0]  a [2];
        logic [31:0] d [2];
        bit   [1:0]  p, pend;
        bit          sup, done;
        logic [31:0] sd;
        int          w, o, cyc;
        txn_t        t;
        kind_e       k [2];

        for (int c = 0; c < 2; c++) begin
            k[c]       = kind_e'($urandom_range(0, 5));
            rk[c]      = k[c];
            a[c]       = 5'($urandom_range(0, 31));
            d[c]       = $urandom;
            snp_mod[c] = 1'($urandom_range(0, 1));
            snp_dat[c] = $urandom;
            p[c]       = (k[c] != K_NONE);
        end
        pend = p;

        expq.delete();
        while (p != 2'b00) begin
            w = pick(p);
            o = 1 - w;
            t.core = w; t.kind = k[w]; t.addr = 32'(a[w]); t.data = '0;
            case (k[w])
                K_IRD: t.data = ref_mem[a[w]];
                K_DWR: ref_mem[a[w]] = d[w];
                K_DRD, K_DRX: begin
                    if (p[o] && is_d(k[o])) begin
                        sup = (k[o] == K_DRX) || (k[o] == K_UPG);
                        sd  = d[o];
                    end else begin
                        sup = snp_mod[o];
                        sd  = snp_dat[o];
                    end
                    if (sup) begin
                        t.data = sd;
                        ref_mem[a[w]] = sd;
                    end else begin
                        t.data = ref_mem[a[w]];
                    end
                end
                default: ;
            endcase
            expq.push_back(t);
            p[w]   = 1'b0;
            m_last = w;
        end

        tick();
        for (int c = 0; c < 2; c++) drive_req(c, k[c], 32'(a[c]), d[c]);
        bus.ram_ready = ($urandom_range(0, 3) != 0);
        cyc = 0;
        while (1) begin
            settle();
            check_eq("ram_excl", 64'(bus.ramREN & bus.ramWEN), 64'd0);
            if (expq.size() > 0) check_eq("ccwait_to_grant", 64'(bus.ccwait[expq[0].core]), 64'd0);
            for (int c = 0; c < 2; c++)
                if (!pend[c]) check_eq("idle_wait", 64'({bus.iwait[c], bus.dwait[c]}), 64'd3);
            for (int c = 0; c < 2; c++) begin
                if (pend[c]) begin
                    if (k[c] == K_UPG)      done = bus.ccinv[1-c] && bus.ccwait[1-c];
                    else if (k[c] == K_IRD) done = !bus.iwait[c];
                    else                    done = !bus.dwait[c];
                    if (done) begin
                        if (expq.size() == 0) begin
                            check_eq("spurious_done", 64'(c + 1), 64'd0);
                        end else begin
                            t = expq.pop_front();
                            check_eq("order_core", 64'(c), 64'(t.core));
                            case (k[c])
                                K_IRD:        check_eq("iload", 64'(bus.iload[c]), 64'(t.data));
                                K_DRD, K_DRX: check_eq("dload", 64'(bus.dload[c]), 64'(t.data));
                                K_UPG:        check_eq("inv_addr", 64'(bus.ccsnoopaddr[1-c]), 64'(t.addr));
                                default: ;
                            endcase
                        end
                        pend[c] = 1'b0;
                    end
                end
            end
            if (pend == 2'b00) break;
            cyc++;
            if (cyc > 80) begin
                check_eq("round_timeout", 64'(pend), 64'd0);
                break;
            end
            tick();
            for (int c = 0; c < 2; c++) if (!pend[c]) drive_req(c, K_NONE, 32'h0, 32'h0);
            bus.ram_ready = ($urandom_range(0, 3) != 0);
        end
        check_eq("leftover_txn", 64'(expq.size()), 64'd0);
        tick();
        for (int c = 0; c < 2; c++) drive_req(c, K_NONE, 32'h0, 32'h0);
        settle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before 1ms");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h5A00_0000 + 32'(i * 13);
        for (int i = 0; i < 32; i++) ref_mem[i] = ram_mem[i];
        ram_mem[10'h40] = 32'h0BAD_F00D;
        ram_mem[10'h80] = 32'hDEAD_BEEF;
        ram_mem[10'h44] = 32'h4444_0044;
        bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.daddr = '0; bus.dstore = '0; bus.ccwrite = '0;
        bus.ramload = '0; bus.ram_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            snp_dat[c] = '0; snp_mod[c] = 1'b0; dbusy[c] = 1'b0; rk[c] = K_NONE;
        end

        // Reset state
        tick();
        settle();
        check_eq("rst_iwait", 64'(bus.iwait), 64'd3);
        check_eq("rst_dwait", 64'(bus.dwait), 64'd3);
        check_eq("rst_ram", 64'({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore}), 64'd0);
        check_eq("rst_cc", 64'({bus.ccwait, bus.ccinv, bus.ccsnoopaddr}), 64'd0);
        check_eq("rst_load", 64'({bus.iload, bus.dload}), 64'd0);
        do_reset();

        // Writeback with RAM stalled for 5 cycles
        tick();
        drive_req(0, K_DWR, 32'h300, 32'hCAFE_0001);
        settle();
        check_eq("wb_idle_dwait", 64'(bus.dwait), 64'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            check_eq("wb_stall_wen", 64'({bus.ramREN, bus.ramWEN}), 64'd1);
            check_eq("wb_stall_addr", 64'(bus.ramaddr), 64'h300);
            check_eq("wb_stall_data", 64'(bus.ramstore), 64'hCAFE_0001);
            check_eq("wb_stall_dwait", 64'(bus.dwait), 64'd3);
        end
        tick();
        bus.ram_ready = 1'b1;
        settle();
        check_eq("wb_done_dwait", 64'(bus.dwait), 64'd2);
        tick();
        drive_req(0, K_NONE, 32'h0, 32'h0);
        bus.ram_ready = 1'b0;
        settle();
        check_eq("wb_after_dwait", 64'(bus.dwait), 64'd3);
        check_eq("wb_ram", 64'(ram_mem[10'h300]), 64'hCAFE_0001);

        // Upgrade from core0
        tick();
        drive_req(0, K_UPG, 32'h200, 32'h0);
        settle();
        tick();
        settle();
        check_eq("upg_ccwait", 64'(bus.ccwait), 64'd2);
        check_eq("upg_ccinv", 64'(bus.ccinv), 64'd2);
        check_eq("upg_addr", 64'(bus.ccsnoopaddr[1]), 64'h200);
        check_eq("upg_noram", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
        check_eq("upg_dwait", 64'(bus.dwait), 64'd3);
        tick();
        drive_req(0, K_NONE, 32'h0, 32'h0);
        settle();
        check_eq("upg_one_cycle", 64'(bus.ccwait), 64'd0);

        // Read-exclusive hitting a Modified line in core1
        tick();
        drive_req(0, K_DRX, 32'h100, 32'h0);
        snp_mod[1] = 1'b1; snp_dat[1] = 32'h1234_5678;
        bus.ram_ready = 1'b1;
        settle();
        tick();
        settle();
        check_eq("c2c_snoop_inv", 64'({bus.ccwait, bus.ccinv}), 64'hA);
        check_eq("c2c_snoop_addr", 64'(bus.ccsnoopaddr[1]), 64'h100);
        check_eq("c2c_snoop_ren", 64'(bus.ramREN), 64'd0);
        tick();
        settle();
        check_eq("c2c_wen", 64'({bus.ramREN, bus.ramWEN}), 64'd1);
        check_eq("c2c_store", 64'(bus.ramstore), 64'h1234_5678);
        check_eq("c2c_dload", 64'(bus.dload[0]), 64'h1234_5678);
        check_eq("c2c_dwait", 64'(bus.dwait), 64'd2);
        tick();
        drive_req(0, K_NONE, 32'h0, 32'h0);
        snp_mod[1] = 1'b0;
        settle();

        // Core0 ifetch vs core1 dcache read: dcache first
        tick();
        drive_req(0, K_IRD, 32'h40, 32'h0);
        drive_req(1, K_DRD, 32'h80, 32'h0);
        settle();
        tick();
        settle();
        check_eq("mix_snoop_ccwait", 64'(bus.ccwait), 64'd1);
        tick();
        settle();
        check_eq("mix_ccwait_gone", 64'(bus.ccwait), 64'd0);
        check_eq("mix_dload", 64'(bus.dload[1]), 64'hDEAD_BEEF);
        check_eq("mix_dwait", 64'(bus.dwait), 64'd1);
        check_eq("mix_iwait_held", 64'(bus.iwait), 64'd3);
        tick();
        drive_req(1, K_NONE, 32'h0, 32'h0);
        settle();
        tick();
        settle();
        check_eq("mix_iload", 64'(bus.iload[0]), 64'h0BAD_F00D);
        check_eq("mix_iwait", 64'(bus.iwait), 64'd2);
        tick();
        drive_req(0, K_NONE, 32'h0, 32'h0);
        settle();

        // Reset during MEMRD, then re-issue
        tick();
        drive_req(0, K_DRD, 32'h44, 32'h0);
        bus.ram_ready = 1'b0;
        settle();
        tick();
        settle();
        tick();
        settle();
        check_eq("rmid_memrd_ren", 64'(bus.ramREN), 64'd1);
        tick();
        RST = 1'b1;
        #1;
        check_eq("rmid_ren", 64'(bus.ramREN), 64'd0);
        check_eq("rmid_dwait", 64'(bus.dwait), 64'd3);
        check_eq("rmid_ccwait", 64'(bus.ccwait), 64'd0);
        settle();
        tick();
        RST = 1'b0;
        bus.ram_ready = 1'b1;
        settle();
        check_eq("rmid_idle", 64'({bus.ramREN, bus.ramWEN, bus.ccwait}), 64'd0);
        tick();
        settle();
        tick();
        settle();
        check_eq("rmid_reissue_dload", 64'(bus.dload[0]), 64'h4444_0044);
        check_eq("rmid_reissue_dwait", 64'(bus.dwait), 64'd2);
        tick();
        drive_req(0, K_NONE, 32'h0, 32'h0);
        settle();

        // Both cores writing back continuously
        do_reset();
        tick();
        drive_req(0, K_DWR, 32'h310, 32'h0000_0310);
        drive_req(1, K_DWR, 32'h311, 32'h0000_0311);
        bus.ram_ready = 1'b1;
        settle();
        grants.delete();
        for (int i = 0; i < 12; i++) begin
            tick();
            settle();
            if (bus.dwait != 2'b11) grants.push_back(bus.dwait[0] ? 1 : 0);
        end
        check_eq("alt_count", 64'(grants.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check_eq("alt_grant", 64'(grants[i]), RR ? 64'(i % 2) : 64'd0);

        // Randomized rounds against the transaction model
        do_reset();
        for (int r = 0; r < 150; r++) run_round();
        for (int i = 0; i < 32; i++) check_eq("final_mem", 64'(ram_mem[i]), 64'(ref_mem[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
